// File: rtl/pace_pkg.sv
// ============================================================================
// Module   : pace_pkg
// Purpose  : Shared channel-state encoding and default sizing for the pace catcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OUT   = 2'd1,
    ST_BLANK = 2'd2
  } ch_state_t;

  localparam int unsigned C_DEF_N_CH        = 2;
  localparam int unsigned C_DEF_CNT_W       = 16;
  localparam int unsigned C_DEF_BLANK_TICKS = 15;

endpackage

`default_nettype wire

// File: rtl/pace_channel.sv
// ============================================================================
// Module   : pace_channel
// Purpose  : One pace input: 2-flop synchroniser, edge detect, tick-counted
//            stretcher FSM. Blanking exists only with PACE_CATCHER_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pace_channel
  import pace_pkg::*;
#(
  parameter int unsigned CNT_W       = C_DEF_CNT_W,
  parameter int unsigned RETRIG      = 0,
  parameter int unsigned BLANK_TICKS = C_DEF_BLANK_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             signal_i,
  output logic             pulse_o,
  output logic             miss_o
);

  logic             r_s1, r_s2, r_s3;
  logic             w_rise;
  ch_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_miss, w_miss_nxt;
  logic [CNT_W-1:0] w_last;

  // Synchroniser runs regardless of enable so a level already high is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= signal_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_last = (width_i == '0) ? '0 : width_i - CNT_W'(1);

`ifdef PACE_CATCHER_BLANK_EN
  localparam logic [CNT_W-1:0] c_blank_last =
    CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
`else
  logic w_unused_blank;
  assign w_unused_blank = (BLANK_TICKS != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_miss_nxt  = 1'b0;
    if (!en_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_OUT;
            w_cnt_nxt   = '0;
          end
        end
        ST_OUT: begin
          if (w_rise && (RETRIG != 0)) begin
            w_cnt_nxt = '0;
          end else begin
            w_miss_nxt = w_rise;
            if (tick_i) begin
              if (r_cnt >= w_last) begin
                w_cnt_nxt = '0;
`ifdef PACE_CATCHER_BLANK_EN
                w_state_nxt = (BLANK_TICKS == 0) ? ST_IDLE : ST_BLANK;
`else
                w_state_nxt = ST_IDLE;
`endif
              end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
              end
            end
          end
        end
`ifdef PACE_CATCHER_BLANK_EN
        ST_BLANK: begin
          w_miss_nxt = w_rise;
          if (tick_i) begin
            if (r_cnt >= c_blank_last) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  assign pulse_o = (r_state == ST_OUT);
  assign miss_o  = r_miss;

endmodule

`default_nettype wire

// File: rtl/multi_pace_catcher.sv
// ============================================================================
// Module   : multi_pace_catcher
// Purpose  : N_CH independent pace catchers sharing clk, tick and width.
//            Optional blanking state enabled by PACE_CATCHER_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_pace_catcher
  import pace_pkg::*;
#(
  parameter int unsigned N_CH        = C_DEF_N_CH,
  parameter int unsigned CNT_W       = C_DEF_CNT_W,
  parameter int unsigned RETRIG      = 0,
  parameter int unsigned BLANK_TICKS = C_DEF_BLANK_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic [N_CH-1:0]  en_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [N_CH-1:0]  signal_i,
  output logic [N_CH-1:0]  pulse_o,
  output logic [N_CH-1:0]  miss_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pace_channel #(
      .CNT_W       (CNT_W),
      .RETRIG      (RETRIG),
      .BLANK_TICKS (BLANK_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_i),
      .en_i     (en_i[g]),
      .width_i  (width_i),
      .signal_i (signal_i[g]),
      .pulse_o  (pulse_o[g]),
      .miss_o   (miss_o[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_pace_catcher.sv
// ============================================================================
// Module   : tb_multi_pace_catcher
// Purpose  : Event scoreboard bench for a RETRIG=0 and a RETRIG=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_pace_catcher;

  localparam int TP = 4;  // tick period in clocks

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_RISE = 2'd1;
  localparam logic [1:0] K_FALL = 2'd2;
  localparam logic [1:0] K_MISS = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [0:0]  ch;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_i = 1'b0;
  logic [1:0]  en_i = 2'b11;
  logic [15:0] width_i = 16'd15;
  logic [1:0]  signal_i = 2'b00;
  logic [1:0]  pulse0, miss0, pulse1, miss1;
  logic [1:0]  prev0 = 2'b00, prev1 = 2'b00;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  multi_pace_catcher #(.N_CH(2), .CNT_W(16), .RETRIG(0), .BLANK_TICKS(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .en_i(en_i), .width_i(width_i),
    .signal_i(signal_i), .pulse_o(pulse0), .miss_o(miss0));

  multi_pace_catcher #(.N_CH(2), .CNT_W(16), .RETRIG(1), .BLANK_TICKS(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .en_i(en_i), .width_i(width_i),
    .signal_i(signal_i), .pulse_o(pulse1), .miss_o(miss1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick is sampled high on every clock edge whose number is a multiple of TP.
  always @(posedge clk) begin
    #1;
    tick_i = (((cyc + 1) % TP) == 0);
  end

  function automatic ev_t mk(input logic [1:0] k, input int ch, input int c);
    ev_t e;
    e.kind = k;
    e.ch   = ch[0:0];
    e.cyc  = c;
    return e;
  endfunction

  function automatic int nth_tick(input int e, input int w);
    return ((e / TP) + 1) * TP + (w - 1) * TP;
  endfunction

  // which: 0 = RETRIG=0 instance, 1 = RETRIG=1 instance, 2 = both
  function automatic void push(input int which, input logic [1:0] k, input int ch, input int c);
    if (which != 1) q0.push_back(mk(k, ch, c));
    if (which != 0) q1.push_back(mk(k, ch, c));
  endfunction

  task automatic check(input int d, input ev_t got);
    ev_t e;
    e = mk(K_NONE, 0, 0);
    if (d == 0 && q0.size() > 0) e = q0.pop_front();
    if (d == 1 && q1.size() > 0) e = q1.pop_front();
    n_vec++;
    assert (got === e) else begin
      n_err++;
      $error("FAIL event dut%0d: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc=%0d",
             d, got.kind, got.ch, got.cyc, e.kind, e.ch, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (pulse0[c] !== prev0[c]) check(0, mk(pulse0[c] ? K_RISE : K_FALL, c, cyc));
      if (miss0[c] === 1'b1)      check(0, mk(K_MISS, c, cyc));
      if (pulse1[c] !== prev1[c]) check(1, mk(pulse1[c] ? K_RISE : K_FALL, c, cyc));
      if (miss1[c] === 1'b1)      check(1, mk(K_MISS, c, cyc));
    end
    prev0 = pulse0;
    prev1 = pulse1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag, input int n);
    step(n);
    n_vec++;
    assert (q0.size() === 0) else begin
      n_err++;
      $error("FAIL %s dut0 pending events: got %0d, expected 0", tag, q0.size());
    end
    n_vec++;
    assert (q1.size() === 0) else begin
      n_err++;
      $error("FAIL %s dut1 pending events: got %0d, expected 0", tag, q1.size());
    end
    q0.delete();
    q1.delete();
  endtask

  int k, r, f, t;

  initial begin
    // Reset state
    step(3);
    n_vec++;
    assert ({pulse0, miss0, pulse1, miss1} === 8'h00) else begin
      n_err++;
      $error("FAIL reset outputs: got %h, expected 00", {pulse0, miss0, pulse1, miss1});
    end
    rst_n = 1'b1;
    step(5);

    // Basic pulse, width 15, ch0 high for 3 clocks; ch1 must stay quiet
    width_i = 16'd15;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, nth_tick(r, 15));
    step(3);
    signal_i[0] = 1'b0;
    drain("basic", 120);

    // Level held for 200 ticks yields a single pulse
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, nth_tick(r, 15));
    step(200 * TP);
    signal_i[0] = 1'b0;
    drain("held", 120);

    // Second edge at tick 10 of the pulse
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    t = nth_tick(r, 10);
    push(2, K_RISE, 0, r);
    push(0, K_MISS, 0, t);
    push(0, K_FALL, 0, nth_tick(r, 15));
    push(1, K_FALL, 0, nth_tick(t, 15));
    step(3);
    signal_i[0] = 1'b0;
    goto(t - 3);
    signal_i[0] = 1'b1;
    step(3);
    signal_i[0] = 1'b0;
    drain("retrig", 160);

    // width 0 behaves as width 1
    width_i = 16'd0;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, nth_tick(r, 1));
    step(3);
    signal_i[0] = 1'b0;
    drain("width0", 60);

    // Edge coincident with the final tick
    width_i = 16'd4;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    f = nth_tick(r, 4);
    push(2, K_RISE, 0, r);
    push(0, K_FALL, 0, f);
    push(0, K_MISS, 0, f);
    push(1, K_FALL, 0, nth_tick(f, 4));
    step(3);
    signal_i[0] = 1'b0;
    goto(f - 3);
    signal_i[0] = 1'b1;
    step(3);
    signal_i[0] = 1'b0;
    drain("final_tick", 80);

`ifndef PACE_CATCHER_BLANK_EN
    // Edge one clock after exit is accepted
    width_i = 16'd2;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    f = nth_tick(r, 2);
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, f);
    push(2, K_RISE, 0, f + 1);
    push(2, K_FALL, 0, nth_tick(f + 1, 2));
    step(3);
    signal_i[0] = 1'b0;
    goto(f - 2);
    signal_i[0] = 1'b1;
    step(3);
    signal_i[0] = 1'b0;
    drain("reaccept", 60);
`else
    // Blanking of 5 ticks after the pulse
    width_i = 16'd4;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    f = nth_tick(r, 4);
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, f);
    push(2, K_MISS, 0, f + 2 * TP);
    push(2, K_RISE, 0, f + 6 * TP);
    push(2, K_FALL, 0, nth_tick(f + 6 * TP, 4));
    step(3);
    signal_i[0] = 1'b0;
    goto(f + 2 * TP - 3);
    signal_i[0] = 1'b1;
    step(3);
    signal_i[0] = 1'b0;
    goto(f + 6 * TP - 3);
    signal_i[0] = 1'b1;
    step(3);
    signal_i[0] = 1'b0;
    drain("blank", 100);
`endif

    // Enable dropped mid-pulse; re-enable with input still high does not trigger
    width_i = 16'd15;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, r + 11);
    goto(r + 10);
    en_i[0] = 1'b0;
    step(20);
    en_i[0] = 1'b1;
    step(20);
    signal_i[0] = 1'b0;
    drain("enable", 100);

    // Channel 1 on its own, width 3
    width_i = 16'd3;
    signal_i[1] = 1'b1; k = cyc + 1;
    r = k + 2;
    push(2, K_RISE, 1, r);
    push(2, K_FALL, 1, nth_tick(r, 3));
    step(3);
    signal_i[1] = 1'b0;
    drain("ch1", 80);

    // Reset mid-pulse with the input still high at release
    width_i = 16'd15;
    signal_i[0] = 1'b1; k = cyc + 1;
    r = k + 2;
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, r + 5);
    goto(r + 5);
    rst_n = 1'b0;
    #1;
    n_vec++;
    assert ({pulse0[0], pulse1[0]} === 2'b00) else begin
      n_err++;
      $error("FAIL async_reset pulse: got %b, expected 00", {pulse0[0], pulse1[0]});
    end
    step(3);
    rst_n = 1'b1;
    r = cyc + 3;
    push(2, K_RISE, 0, r);
    push(2, K_FALL, 0, nth_tick(r, 15));
    step(10);
    signal_i[0] = 1'b0;
    drain("reset_release", 120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
